// File: rtl/hf_seq_pkg.sv
// Shared opcodes, mod_type codes and FSM encoding for the HF reader sequencer.
package hf_seq_pkg;

  localparam logic [3:0] CMD_SET_CONF    = 4'h1;
  localparam logic [3:0] CMD_TX          = 4'h2;
  localparam logic [3:0] CMD_SET_TIMEOUT = 4'h3;
  localparam logic [3:0] CMD_ABORT       = 4'hF;

  localparam logic [2:0] MOD_SNIFFER       = 3'b000;
  localparam logic [2:0] MOD_TAGSIM_LISTEN = 3'b001;
  localparam logic [2:0] MOD_TAGSIM_MOD    = 3'b010;
  localparam logic [2:0] MOD_READER_LISTEN = 3'b011;
  localparam logic [2:0] MOD_READER_MOD    = 3'b100;

  localparam int CNT_W = 12;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TX,
    ST_GUARD,
    ST_LISTEN,
    ST_RESP
  } seq_state_e;

  // Slot counters stop at zero instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_dec(input logic [CNT_W-1:0] v);
    return (v == '0) ? v : v - {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/hf_cmd_fifo.sv
// Small show-ahead command FIFO on the carrier negedge, with synchronous flush.
module hf_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             nrst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  // Fullness is judged before any same-cycle pop.
  assign do_push = push_i && !full_o && !flush_i;
  assign do_pop  = pop_i && !empty_o && !flush_i;
  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(negedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(negedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/hf_reader_sequencer.sv
// Command-queued TX/guard/listen/response sequencer driving the HF datapath mod_type.
// Optional HF_SEQ_STATS_EN adds saturating response/timeout counters.
module hf_reader_sequencer
  import hf_seq_pkg::*;
#(
  parameter int CMD_DEPTH  = 4,
  parameter int GUARD_BITS = 9,
  parameter int EOF_BITS   = 2,
  parameter int TO_DEFAULT = 256
) (
  input  logic        ck_1356meg,
  input  logic        nrst,
  input  logic        bit_strobe,
  input  logic        curbit,
  input  logic        cmd_valid,
  input  logic [15:0] cmd_word,
  output logic        cmd_ready,
  output logic [2:0]  mod_type,
  output logic        busy,
  output logic        resp_start,
  output logic        resp_done,
  output logic        timeout
`ifdef HF_SEQ_STATS_EN
  ,
  output logic [15:0] resp_cnt,
  output logic [15:0] timeout_cnt
`endif
);

  localparam logic [CNT_W-1:0] GUARD_LD = CNT_W'(GUARD_BITS);
  localparam logic [CNT_W-1:0] TO_RST   = CNT_W'(TO_DEFAULT);
  localparam logic [CNT_W-1:0] EOF_LIM  = CNT_W'(EOF_BITS);

  seq_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] quiet_q;
  logic [CNT_W-1:0] quiet_d;
  logic [CNT_W-1:0] timeout_bits_q;
  logic [2:0]       idle_mode_q;
  logic [2:0]       mod_type_q;
  logic             abort_pend_q;
  logic             resp_start_q;
  logic             resp_done_q;
  logic             timeout_q;

  logic             abort_acc;
  logic             push;
  logic             pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [15:0]      fifo_rdata;
  logic [3:0]       pop_op;
  logic [11:0]      pop_d;

  // ABORT never enters the FIFO, so it is taken even while the FIFO is full.
  assign abort_acc = cmd_valid && (cmd_word[15:12] == CMD_ABORT);
  assign push      = cmd_valid && cmd_ready && !abort_acc;
  assign pop       = bit_strobe && (state_q == ST_IDLE) && !fifo_empty &&
                     !abort_acc && !abort_pend_q;
  assign pop_op    = fifo_rdata[15:12];
  assign pop_d     = fifo_rdata[11:0];
  assign quiet_d   = (quiet_q == {CNT_W{1'b1}}) ? quiet_q : quiet_q + 1'b1;

  hf_cmd_fifo #(
    .DEPTH (CMD_DEPTH),
    .WIDTH (16)
  ) u_fifo (
    .clk_i   (ck_1356meg),
    .nrst_i  (nrst),
    .push_i  (push),
    .wdata_i (cmd_word),
    .pop_i   (pop),
    .flush_i (abort_acc),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_ff @(negedge ck_1356meg or negedge nrst) begin
    if (!nrst) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      quiet_q        <= '0;
      timeout_bits_q <= TO_RST;
      idle_mode_q    <= MOD_SNIFFER;
      mod_type_q     <= MOD_SNIFFER;
      abort_pend_q   <= 1'b0;
      resp_start_q   <= 1'b0;
      resp_done_q    <= 1'b0;
      timeout_q      <= 1'b0;
    end else begin
      resp_start_q <= 1'b0;
      resp_done_q  <= 1'b0;
      timeout_q    <= 1'b0;
      if (abort_acc) abort_pend_q <= 1'b1;

      if (bit_strobe) begin
        if (abort_acc || abort_pend_q) begin
          abort_pend_q <= 1'b0;
          state_q      <= ST_IDLE;
          mod_type_q   <= idle_mode_q;
          cnt_q        <= '0;
          quiet_q      <= '0;
        end else begin
          case (state_q)
            ST_IDLE: begin
              mod_type_q <= idle_mode_q;
              if (pop) begin
                case (pop_op)
                  CMD_SET_CONF: begin
                    idle_mode_q <= pop_d[2:0];
                    mod_type_q  <= pop_d[2:0];
                  end
                  CMD_TX: begin
                    state_q    <= ST_TX;
                    cnt_q      <= (pop_d == '0) ? CNT_W'(1) : pop_d;
                    mod_type_q <= MOD_READER_MOD;
                  end
                  CMD_SET_TIMEOUT: timeout_bits_q <= pop_d;
                  default: ;
                endcase
              end
            end
            ST_TX: begin
              if (cnt_q <= CNT_W'(1)) begin
                mod_type_q <= MOD_READER_LISTEN;
                if (GUARD_LD == '0) begin
                  state_q <= ST_LISTEN;
                  cnt_q   <= timeout_bits_q;
                end else begin
                  state_q <= ST_GUARD;
                  cnt_q   <= GUARD_LD;
                end
              end else begin
                cnt_q <= sat_dec(cnt_q);
              end
            end
            ST_GUARD: begin
              if (cnt_q <= CNT_W'(1)) begin
                state_q <= ST_LISTEN;
                cnt_q   <= timeout_bits_q;
              end else begin
                cnt_q <= sat_dec(cnt_q);
              end
            end
            // A zero timeout leaves cnt at 0, so the window never expires.
            ST_LISTEN: begin
              if (curbit) begin
                state_q      <= ST_RESP;
                resp_start_q <= 1'b1;
                quiet_q      <= '0;
              end else if (cnt_q == CNT_W'(1)) begin
                state_q    <= ST_IDLE;
                timeout_q  <= 1'b1;
                mod_type_q <= idle_mode_q;
                cnt_q      <= '0;
              end else begin
                cnt_q <= sat_dec(cnt_q);
              end
            end
            ST_RESP: begin
              if (curbit) begin
                quiet_q <= '0;
              end else if (quiet_d >= EOF_LIM) begin
                state_q     <= ST_IDLE;
                resp_done_q <= 1'b1;
                mod_type_q  <= idle_mode_q;
                quiet_q     <= '0;
              end else begin
                quiet_q <= quiet_d;
              end
            end
            default: state_q <= ST_IDLE;
          endcase
        end
      end
    end
  end

  assign cmd_ready  = !fifo_full;
  assign busy       = (state_q != ST_IDLE) || !fifo_empty;
  assign mod_type   = mod_type_q;
  assign resp_start = resp_start_q;
  assign resp_done  = resp_done_q;
  assign timeout    = timeout_q;

`ifdef HF_SEQ_STATS_EN
  logic [15:0] resp_cnt_q;
  logic [15:0] timeout_cnt_q;

  always_ff @(negedge ck_1356meg or negedge nrst) begin
    if (!nrst) begin
      resp_cnt_q    <= '0;
      timeout_cnt_q <= '0;
    end else if (abort_acc) begin
      resp_cnt_q    <= '0;
      timeout_cnt_q <= '0;
    end else begin
      if (resp_start_q && (resp_cnt_q != 16'hFFFF))  resp_cnt_q    <= resp_cnt_q + 16'd1;
      if (timeout_q && (timeout_cnt_q != 16'hFFFF)) timeout_cnt_q <= timeout_cnt_q + 16'd1;
    end
  end

  assign resp_cnt    = resp_cnt_q;
  assign timeout_cnt = timeout_cnt_q;
`endif

endmodule

// File: tb/tb_hf_reader_sequencer.sv
// Scoreboard bench: tasks queue expected mod_type changes and pulses by bit-slot number.
module tb_hf_reader_sequencer;

  localparam int DEPTH  = 4;
  localparam int GUARD  = 9;
  localparam int EOFB   = 2;
  localparam int TO_DEF = 256;

  localparam logic [2:0] K_MOD   = 3'd1;
  localparam logic [2:0] K_START = 3'd2;
  localparam logic [2:0] K_DONE  = 3'd3;
  localparam logic [2:0] K_TO    = 3'd4;

  typedef struct packed {
    logic [2:0]  kind;
    logic [2:0]  val;
    logic [31:0] slot;
  } ev_t;

  logic        ck = 1'b0;
  logic        nrst = 1'b0;
  logic        bit_strobe = 1'b0;
  logic        curbit = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [15:0] cmd_word = 16'h0;
  logic        cmd_ready;
  logic [2:0]  mod_type;
  logic        busy;
  logic        resp_start;
  logic        resp_done;
  logic        timeout;
`ifdef HF_SEQ_STATS_EN
  logic [15:0] resp_cnt;
  logic [15:0] timeout_cnt;
`endif

  int         n_tests = 0;
  int         n_fail  = 0;
  int         slot    = 0;
  bit         cb_hi[int];
  ev_t        exp_q[$];
  logic       mon_en = 1'b0;
  logic [2:0] mod_prev = 3'b000;

  always #5 ck = ~ck;

  hf_reader_sequencer #(
    .CMD_DEPTH  (DEPTH),
    .GUARD_BITS (GUARD),
    .EOF_BITS   (EOFB),
    .TO_DEFAULT (TO_DEF)
  ) dut (
    .ck_1356meg (ck),
    .nrst       (nrst),
    .bit_strobe (bit_strobe),
    .curbit     (curbit),
    .cmd_valid  (cmd_valid),
    .cmd_word   (cmd_word),
    .cmd_ready  (cmd_ready),
    .mod_type   (mod_type),
    .busy       (busy),
    .resp_start (resp_start),
    .resp_done  (resp_done),
    .timeout    (timeout)
`ifdef HF_SEQ_STATS_EN
    ,
    .resp_cnt    (resp_cnt),
    .timeout_cnt (timeout_cnt)
`endif
  );

  // Bit strobe every 16 clocks; curbit is raised only in the strobe cycles listed in cb_hi.
  initial begin : strobe_gen
    int phase;
    phase = 0;
    forever begin
      @(posedge ck);
      if (phase == 0) begin
        slot++;
        bit_strobe = 1'b1;
        curbit = (cb_hi.exists(slot) != 0);
      end else begin
        bit_strobe = 1'b0;
        curbit = 1'b0;
      end
      phase = (phase + 1) % 16;
    end
  end

  // Observed events are matched in order against the expected queue.
  initial begin : monitor
    ev_t obs[$];
    ev_t e;
    forever begin
      @(negedge ck);
      #2;
      if (mon_en) begin
        obs = {};
        if (mod_type !== mod_prev) begin
          obs.push_back('{K_MOD, mod_type, 32'(slot)});
          mod_prev = mod_type;
        end
        if (resp_start !== 1'b0) obs.push_back('{K_START, 3'd0, 32'(slot)});
        if (resp_done !== 1'b0)  obs.push_back('{K_DONE, 3'd0, 32'(slot)});
        if (timeout !== 1'b0)    obs.push_back('{K_TO, 3'd0, 32'(slot)});
        foreach (obs[i]) begin
          n_tests++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_event: got kind=%0d val=%0d slot=%0d, required no event",
                     obs[i].kind, obs[i].val, obs[i].slot);
          end else begin
            e = exp_q.pop_front();
            if (obs[i] !== e || bit_strobe !== 1'b1) begin
              n_fail++;
              $display("FAIL scoreboard_event: got kind=%0d val=%0d slot=%0d strobe_aligned=%0b, required kind=%0d val=%0d slot=%0d strobe_aligned=1",
                       obs[i].kind, obs[i].val, obs[i].slot, bit_strobe, e.kind, e.val, e.slot);
            end
          end
        end
      end
    end
  end

  initial begin : watchdog
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic expect_ev(input logic [2:0] k, input logic [2:0] v, input int s);
    ev_t e;
    e.kind = k;
    e.val  = v;
    e.slot = 32'(s);
    exp_q.push_back(e);
  endtask

  task automatic sync(output int s);
    @(negedge ck);
    while (bit_strobe !== 1'b1) @(negedge ck);
    s = slot;
  endtask

  task automatic push(input logic [15:0] w, output logic acc);
    @(posedge ck);
    cmd_valid = 1'b1;
    cmd_word  = w;
    acc       = cmd_ready;
  endtask

  task automatic end_push();
    @(posedge ck);
    cmd_valid = 1'b0;
    cmd_word  = 16'h0;
    #1;
  endtask

  task automatic run_to(input int target);
    int guard;
    guard = 0;
    while (slot <= target && guard < 20000) begin
      @(posedge ck);
      guard++;
    end
    @(negedge ck);
    #3;
  endtask

  task automatic test_reset();
    nrst = 1'b0;
    repeat (3) @(posedge ck);
    #1;
    n_tests++;
    if (mod_type !== 3'b000) begin n_fail++; $display("FAIL reset_mod_type: got %b, required 000", mod_type); end
    n_tests++;
    if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_cmd_ready: got %b, required 1", cmd_ready); end
    n_tests++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b, required 0", busy); end
    n_tests++;
    if ({resp_start, resp_done, timeout} !== 3'b000) begin
      n_fail++; $display("FAIL reset_pulses: got %b, required 000", {resp_start, resp_done, timeout});
    end
    @(posedge ck);
    nrst = 1'b1;
    mod_prev = 3'b000;
    mon_en = 1'b1;
    $display("[TB] test_reset done");
  endtask

  task automatic test_set_conf();
    int s;
    logic acc;
    sync(s);
    push(16'h1003, acc);
    end_push();
    expect_ev(K_MOD, 3'b011, s + 1);
    n_tests++;
    if (acc !== 1'b1) begin n_fail++; $display("FAIL set_conf_accept: got %b, required 1", acc); end
    n_tests++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL set_conf_busy_queued: got %b, required 1", busy); end
    run_to(s + 1);
    n_tests++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL set_conf_busy_after: got %b, required 0", busy); end
    n_tests++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL set_conf_events: %0d pending, required 0", exp_q.size()); exp_q.delete(); end
    $display("[TB] test_set_conf done");
  endtask

  task automatic test_tx_timeout();
    int s;
    logic acc;
    sync(s);
    push(16'h1001, acc);
    push(16'h2008, acc);
    end_push();
    expect_ev(K_MOD, 3'b001, s + 1);
    expect_ev(K_MOD, 3'b100, s + 2);
    expect_ev(K_MOD, 3'b011, s + 10);
    expect_ev(K_MOD, 3'b001, s + 10 + GUARD + TO_DEF);
    expect_ev(K_TO,  3'b000, s + 10 + GUARD + TO_DEF);
    run_to(s + 10 + GUARD + TO_DEF + 2);
    n_tests++;
    if (mod_type !== 3'b001) begin n_fail++; $display("FAIL tx_timeout_idle_mode: got %b, required 001", mod_type); end
    n_tests++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL tx_timeout_busy: got %b, required 0", busy); end
    n_tests++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL tx_timeout_events: %0d pending, required 0", exp_q.size()); exp_q.delete(); end
    $display("[TB] test_tx_timeout done");
  endtask

  task automatic test_response();
    int s;
    logic acc;
    sync(s);
    push(16'h2004, acc);
    end_push();
    cb_hi[s + 5 + GUARD + 3] = 1'b1;
    expect_ev(K_MOD,   3'b100, s + 1);
    expect_ev(K_MOD,   3'b011, s + 5);
    expect_ev(K_START, 3'b000, s + 5 + GUARD + 3);
    expect_ev(K_MOD,   3'b001, s + 5 + GUARD + 3 + EOFB);
    expect_ev(K_DONE,  3'b000, s + 5 + GUARD + 3 + EOFB);
    run_to(s + 5 + GUARD + 3 + EOFB + 6);
    n_tests++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL response_busy: got %b, required 0", busy); end
    n_tests++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL response_events: %0d pending, required 0", exp_q.size()); exp_q.delete(); end
    $display("[TB] test_response done");
  endtask

  task automatic test_guard_ignore();
    int s;
    logic acc;
    sync(s);
    push(16'h3014, acc);
    push(16'h2002, acc);
    end_push();
    for (int k = 5; k <= 4 + GUARD; k++) cb_hi[s + k] = 1'b1;
    expect_ev(K_MOD, 3'b100, s + 2);
    expect_ev(K_MOD, 3'b011, s + 4);
    expect_ev(K_MOD, 3'b001, s + 4 + GUARD + 20);
    expect_ev(K_TO,  3'b000, s + 4 + GUARD + 20);
    run_to(s + 4 + GUARD + 20 + 2);
    n_tests++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL guard_ignore_events: %0d pending, required 0", exp_q.size()); exp_q.delete(); end
    $display("[TB] test_guard_ignore done");
  endtask

  task automatic test_final_slot();
    int s;
    logic acc;
    sync(s);
    push(16'h2000, acc);
    end_push();
    cb_hi[s + 2 + GUARD + 20] = 1'b1;
    expect_ev(K_MOD,   3'b100, s + 1);
    expect_ev(K_MOD,   3'b011, s + 2);
    expect_ev(K_START, 3'b000, s + 2 + GUARD + 20);
    expect_ev(K_MOD,   3'b001, s + 2 + GUARD + 20 + EOFB);
    expect_ev(K_DONE,  3'b000, s + 2 + GUARD + 20 + EOFB);
    run_to(s + 2 + GUARD + 20 + EOFB + 5);
    n_tests++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL final_slot_events: %0d pending, required 0", exp_q.size()); exp_q.delete(); end
    $display("[TB] test_final_slot done");
  endtask

  task automatic test_reset_mid_resp();
    int s;
    logic acc;
    sync(s);
    push(16'h2001, acc);
    end_push();
    cb_hi[s + 12] = 1'b1;
    cb_hi[s + 13] = 1'b1;
    cb_hi[s + 14] = 1'b1;
    expect_ev(K_MOD,   3'b100, s + 1);
    expect_ev(K_MOD,   3'b011, s + 2);
    expect_ev(K_START, 3'b000, s + 12);
    run_to(s + 13);
    repeat (4) @(posedge ck);
    n_tests++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL mid_resp_events: %0d pending, required 0", exp_q.size()); exp_q.delete(); end
    mon_en = 1'b0;
    #1;
    nrst = 1'b0;
    #1;
    n_tests++;
    if (mod_type !== 3'b000) begin n_fail++; $display("FAIL mid_resp_reset_mod: got %b, required 000", mod_type); end
    n_tests++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_resp_reset_busy: got %b, required 0", busy); end
    repeat (2) @(posedge ck);
    nrst = 1'b1;
    mod_prev = 3'b000;
    mon_en = 1'b1;
    $display("[TB] test_reset_mid_resp done");
  endtask

  task automatic test_fifo_abort();
    int s;
    int s2;
    logic acc;
    logic [15:0] words [5];
    words[0] = 16'h1005;
    words[1] = 16'h1006;
    words[2] = 16'h1007;
    words[3] = 16'h1002;
    words[4] = 16'h1004;
    sync(s);
    push(16'h2064, acc);
    end_push();
    expect_ev(K_MOD, 3'b100, s + 1);
    sync(s2);
    for (int i = 0; i < 5; i++) begin
      push(words[i], acc);
      n_tests++;
      if (acc !== ((i < DEPTH) ? 1'b1 : 1'b0)) begin
        n_fail++; $display("FAIL fifo_push_%0d_ready: got %b, required %b", i, acc, (i < DEPTH) ? 1'b1 : 1'b0);
      end
    end
    push(16'hF000, acc);
    end_push();
    expect_ev(K_MOD, 3'b000, s2 + 1);
    n_tests++;
    if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL abort_flush_ready: got %b, required 1", cmd_ready); end
    n_tests++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL abort_busy_before_strobe: got %b, required 1", busy); end
    run_to(s2 + 4);
    n_tests++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy_after: got %b, required 0", busy); end
    n_tests++;
    if (mod_type !== 3'b000) begin n_fail++; $display("FAIL abort_mod_type: got %b, required 000", mod_type); end
    n_tests++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL abort_events: %0d pending, required 0", exp_q.size()); exp_q.delete(); end
    $display("[TB] test_fifo_abort done");
  endtask

  initial begin : main
    test_reset();
    test_set_conf();
    test_tx_timeout();
    test_response();
    test_guard_ignore();
    test_final_slot();
    test_reset_mid_resp();
    test_fifo_abort();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
